foreground_linebuf_m: RTL and testbench
=======================================

// Module: foreground_linebuf_m
// PURPOSE
//   Next-generation foreground (sprite) engine. It replaces per-pixel evaluation of every object with per-scanline
//   evaluation plus a ping-pong line buffer. While line N is displayed, an FSM scans OBM for objects on line N+1,
//   keeps up to MAX_PER_LINE of them, fetches their pattern rows from PMF and draws them into the back buffer.
//   Output feeds the same r/g/b/valid mixer input as the foreground stage.
// PARAMETERS
//   NUM_OBJECTS      64   objects in OBM (4 bytes each: xp, yp, {x,hflip,vflip,pmfa[4:0]}, {5'x,color[2:0]})
//   MAX_PER_LINE     8    objects drawn per scanline; extra objects are dropped
//   VRAM_ADDR_WIDTH  10   VRAM write address width
//   PMF_BASE         0    byte address of PMF (512 B, 32 patterns x 8 rows x 2 B)
//   OBM_BASE         512  byte address of OBM (NUM_OBJECTS*4 B)
// PORTS
//   clk         in   1                video clock
//   rst         in   1                asynchronous, active-high reset
//   xp          in   8                current display column
//   visible     in   1                display active
//   line_start  in   1                one-cycle pulse: swap buffers and start evaluating line_y
//   line_y      in   8                line to prepare; sampled when line_start=1
//   vram_we     in   1                VRAM write strobe
//   vram_addr   in   VRAM_ADDR_WIDTH  VRAM write byte address
//   vram_data   in   8                VRAM write data
//   r, g, b     out  2 each           pixel colour, registered
//   valid       out  1                opaque foreground pixel, registered
//   overflow    out  1                more than MAX_PER_LINE objects on the line now displayed
//   overrun     out  1                sticky: line_start arrived before the FSM reached DONE; cleared only by rst
// BEHAVIOUR
//   Reset: r=g=b=0, valid=0, overflow=0, overrun=0, FSM=IDLE, all 2x256 valid bits of both buffers cleared.
//     PMF/OBM contents are not reset.
//   VRAM: a write at an address in the PMF or OBM window lands the same cycle, in any state. Other addresses are ignored.
//     FSM reads see the new value from the next cycle.
//   Buffers: two banks, each 256 x {pix[1:0], color[2:0]} plus 256 valid flops. front=display, back=draw.
//   line_start: toggles front/back; clears all back valid bits in that cycle; latches ty=line_y.
//     overflow <= the back bank's overflow flag; FSM -> SCAN with obj=0 and cnt=0.
//     If FSM!=DONE and !=IDLE at line_start: overrun<=1, the partial line is abandoned, and the new line starts normally.
//   SCAN: 1 object/cycle, objects in ascending index.
//     Hit when yp<=ty && ty<{1'b0,yp}+9'd8, compared 9-bit, no wrap; yp>=249 therefore shows only rows up to line 255.
//     A hit with cnt<MAX_PER_LINE is pushed to the hit list (index order) and cnt++.
//     A hit with cnt==MAX_PER_LINE sets the back overflow flag and is otherwise ignored.
//     After object NUM_OBJECTS-1: go to FETCH if cnt>0, else DONE.
//   FETCH: 1 cycle per listed object. row=ty-yp (3 bits), inverted if vflip. Read the 16-bit PMF line for pmfa/row.
//     If hflip, reverse the order of the 2-bit pixel fields.
//   DRAW: 8 cycles per object; pixel i goes to column xp_obj+i. 9-bit sum; a column >255 is clipped (not written).
//     Write only if pix!=0 and the back valid bit is 0. Lower index therefore wins; transparent pixels never overwrite.
//     After the last listed object -> DONE.
//   DONE: hold until line_start. Worst case 1+NUM_OBJECTS+9*MAX_PER_LINE = 137 cycles, well under the line period.
//   Display: at each clk, the front bank is read at xp; outputs register on the next edge (latency 1).
//     valid = visible && front_valid[xp].
//     r = pix & {2{color[2]}}, g = pix & {2{color[1]}}, b = pix & {2{color[0]}}, all forced to 0 when !valid.
// TESTING
//   1. Reset mid-DRAW, then read every xp: valid=0 and r/g/b=0 at all 256 columns; overrun=0.
//   2. Obj0 at (100,50), pmfa 0, solid pattern 2'b11, color 3'b101. Evaluate line 52 and display it.
//      Columns 100..107 give r=3, g=0, b=3, valid=1; column 99 and column 108 give valid=0. Latency 1 clk.
//   3. Obj3 and obj7 at xp=10 on the same line; obj3 pattern row 2'b00 in its left half; obj7 solid with a different color.
//      Columns 10..13 show obj7's colour; columns 14..17 show obj3's colour.
//   4. Ten objects on line 40: objects 0..7 drawn, objects 8 and 9 absent, overflow=1 while line 40 displays.
//      overflow=0 on the next line, which has 1 object.
//   5. hflip+vflip object at xp=252 with asymmetric pattern: rows and columns are mirrored.
//      Only columns 252..255 are drawn, no wrap to column 0. Object yp=255 appears only on line 255.
//   6. Pulse line_start 20 cycles after the previous one: overrun=1 and stays 1.
//      The next line still renders correctly after a full-length line.

Source files
------------

// File: rtl/foreground_linebuf_if.sv
// foreground_linebuf_if: display timing, VRAM write bus and pixel/status outputs of the line-buffer sprite engine
//   master: drives xp, visible, line_start, line_y, vram_we/addr/data; receives r, g, b, valid, overflow, overrun
//   slave : the engine side of the same signals
interface foreground_linebuf_if #(
    parameter int VRAM_ADDR_WIDTH = 10
);
    logic [7:0]                 xp;
    logic                       visible;
    logic                       line_start;
    logic [7:0]                 line_y;
    logic                       vram_we;
    logic [VRAM_ADDR_WIDTH-1:0] vram_addr;
    logic [7:0]                 vram_data;
    logic [1:0]                 r;
    logic [1:0]                 g;
    logic [1:0]                 b;
    logic                       valid;
    logic                       overflow;
    logic                       overrun;

    modport master (
        output xp, visible, line_start, line_y, vram_we, vram_addr, vram_data,
        input  r, g, b, valid, overflow, overrun
    );

    modport slave (
        input  xp, visible, line_start, line_y, vram_we, vram_addr, vram_data,
        output r, g, b, valid, overflow, overrun
    );
endinterface

// File: rtl/foreground_linebuf_m.sv
// foreground_linebuf_m: per-scanline sprite engine drawing into a ping-pong line buffer
//   clk, rst : video clock, asynchronous active-high reset
//   bus      : slave side of foreground_linebuf_if
//              inputs  xp/visible (display), line_start/line_y (prepare next line), vram_we/addr/data (PMF/OBM writes)
//              outputs r/g/b/valid (registered pixel), overflow (too many objects on shown line), overrun (sticky)
//   PMF row layout: byte 2*row is the high byte; pixel 0 is bits [15:14] of {byte 2*row, byte 2*row+1}.
module foreground_linebuf_m #(
    parameter int NUM_OBJECTS     = 64,
    parameter int MAX_PER_LINE    = 8,
    parameter int VRAM_ADDR_WIDTH = 10,
    parameter int PMF_BASE        = 0,
    parameter int OBM_BASE        = 512
) (
    input logic                clk,
    input logic                rst,
    foreground_linebuf_if.slave bus
);
    localparam int IW = $clog2(NUM_OBJECTS);
    localparam int OW = IW + 2;
    localparam int CW = $clog2(MAX_PER_LINE + 1);
    localparam int HW = $clog2(MAX_PER_LINE);
    localparam int AW = VRAM_ADDR_WIDTH + 1;

    typedef enum logic [2:0] {IDLE, SCAN, FETCH, DRAW, DONE} state_t;

    logic [7:0] pmf_mem [512];
    logic [7:0] obm_mem [NUM_OBJECTS*4];
    logic [1:0] lb_pix  [2][256];
    logic [2:0] lb_col  [2][256];

    state_t          state_q, state_d;
    logic            bank_q, bank_d;
    logic [7:0]      ty_q, ty_d;
    logic [IW-1:0]   obj_q, obj_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   hl_q [MAX_PER_LINE];
    logic [IW-1:0]   hl_d [MAX_PER_LINE];
    logic [HW-1:0]   idx_q, idx_d;
    logic [2:0]      px_q, px_d;
    logic [15:0]     pat_q, pat_d;
    logic [7:0]      xo_q, xo_d;
    logic [2:0]      co_q, co_d;
    logic [1:0]      ovf_q, ovf_d;
    logic [1:0][255:0] vld_q, vld_d;
    logic            overflow_q, overflow_d;
    logic            overrun_q, overrun_d;
    logic            valid_q, valid_d;
    logic [1:0]      r_q, r_d, g_q, g_d, b_q, b_d;

    // One extra bit keeps addresses below a window base from aliasing into it.
    logic [AW-1:0]   pmf_off, obm_off;
    logic            pmf_we, obm_we;
    logic [7:0]      s_yp;
    logic            s_hit;
    logic [IW-1:0]   f_obj;
    logic [1:0]      f_flip;
    logic [4:0]      f_pmfa;
    logic [2:0]      f_row;
    logic [15:0]     f_line, f_rev;
    logic [8:0]      d_col;
    logic [1:0]      d_pix;
    logic            d_we;
    logic [1:0]      o_pix;
    logic [2:0]      o_col;

    always_comb begin
        pmf_off = {1'b0, bus.vram_addr} - AW'(PMF_BASE);
        obm_off = {1'b0, bus.vram_addr} - AW'(OBM_BASE);
        pmf_we  = bus.vram_we && pmf_off < AW'(512);
        obm_we  = bus.vram_we && obm_off < AW'(NUM_OBJECTS * 4);
    end

    always_comb begin
        s_yp   = obm_mem[{obj_q, 2'b01}];
        // 9-bit compare so objects near the bottom never wrap onto the top lines
        s_hit  = s_yp <= ty_q && {1'b0, ty_q} < {1'b0, s_yp} + 9'd8;
        f_obj  = hl_q[idx_q];
        f_flip = obm_mem[{f_obj, 2'b10}][6:5];
        f_pmfa = obm_mem[{f_obj, 2'b10}][4:0];
        f_row  = 3'(ty_q - obm_mem[{f_obj, 2'b01}]) ^ {3{f_flip[0]}};
        f_line = {pmf_mem[{f_pmfa, f_row, 1'b0}], pmf_mem[{f_pmfa, f_row, 1'b1}]};
        f_rev  = '0;
        for (int i = 0; i < 8; i++) f_rev[2*i +: 2] = f_line[14-2*i +: 2];
        d_col  = {1'b0, xo_q} + {6'b0, px_q};
        d_pix  = pat_q[15:14];
        // earlier (lower-index) objects already own their columns; transparent and clipped pixels are skipped
        d_we   = state_q == DRAW && !bus.line_start && d_pix != 2'b00 && !d_col[8]
                 && !vld_q[~bank_q][d_col[7:0]];
    end

    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        ty_d       = ty_q;
        obj_d      = obj_q;
        cnt_d      = cnt_q;
        hl_d       = hl_q;
        idx_d      = idx_q;
        px_d       = px_q;
        pat_d      = pat_q;
        xo_d       = xo_q;
        co_d       = co_q;
        ovf_d      = ovf_q;
        vld_d      = vld_q;
        overflow_d = overflow_q;
        overrun_d  = overrun_q;
        if (bus.line_start) begin
            bank_d         = ~bank_q;
            vld_d[bank_q]  = '0;
            ovf_d[bank_q]  = 1'b0;
            overflow_d     = ovf_q[~bank_q];
            overrun_d      = overrun_q || (state_q != IDLE && state_q != DONE);
            ty_d           = bus.line_y;
            obj_d          = '0;
            cnt_d          = '0;
            state_d        = SCAN;
        end else begin
            case (state_q)
                SCAN: begin
                    if (s_hit && cnt_q < CW'(MAX_PER_LINE)) begin
                        hl_d[cnt_q[HW-1:0]] = obj_q;
                        cnt_d               = cnt_q + CW'(1);
                    end else if (s_hit) begin
                        ovf_d[~bank_q] = 1'b1;
                    end
                    obj_d = obj_q + IW'(1);
                    idx_d = '0;
                    if (obj_q == IW'(NUM_OBJECTS - 1)) state_d = (cnt_d != '0) ? FETCH : DONE;
                end
                FETCH: begin
                    pat_d   = f_flip[1] ? f_rev : f_line;
                    xo_d    = obm_mem[{f_obj, 2'b00}];
                    co_d    = obm_mem[{f_obj, 2'b11}][2:0];
                    px_d    = '0;
                    state_d = DRAW;
                end
                DRAW: begin
                    if (d_we) vld_d[~bank_q][d_col[7:0]] = 1'b1;
                    pat_d = pat_q << 2;
                    px_d  = px_q + 3'd1;
                    if (px_q == 3'd7) begin
                        idx_d   = idx_q + HW'(1);
                        state_d = (CW'(idx_q) + CW'(1) == cnt_q) ? DONE : FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_pix   = lb_pix[bank_q][bus.xp];
        o_col   = lb_col[bank_q][bus.xp];
        valid_d = bus.visible && vld_q[bank_q][bus.xp];
        r_d     = valid_d ? o_pix & {2{o_col[2]}} : 2'b00;
        g_d     = valid_d ? o_pix & {2{o_col[1]}} : 2'b00;
        b_d     = valid_d ? o_pix & {2{o_col[0]}} : 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bank_q     <= 1'b0;
            ty_q       <= '0;
            obj_q      <= '0;
            cnt_q      <= '0;
            hl_q       <= '{default: '0};
            idx_q      <= '0;
            px_q       <= '0;
            pat_q      <= '0;
            xo_q       <= '0;
            co_q       <= '0;
            ovf_q      <= '0;
            vld_q      <= '0;
            overflow_q <= 1'b0;
            overrun_q  <= 1'b0;
            valid_q    <= 1'b0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            ty_q       <= ty_d;
            obj_q      <= obj_d;
            cnt_q      <= cnt_d;
            hl_q       <= hl_d;
            idx_q      <= idx_d;
            px_q       <= px_d;
            pat_q      <= pat_d;
            xo_q       <= xo_d;
            co_q       <= co_d;
            ovf_q      <= ovf_d;
            vld_q      <= vld_d;
            overflow_q <= overflow_d;
            overrun_q  <= overrun_d;
            valid_q    <= valid_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pmf_we) pmf_mem[pmf_off[8:0]] <= bus.vram_data;
        if (obm_we) obm_mem[obm_off[OW-1:0]] <= bus.vram_data;
        if (d_we) begin
            lb_pix[~bank_q][d_col[7:0]] <= d_pix;
            lb_col[~bank_q][d_col[7:0]] <= co_q;
        end
    end

    assign bus.r        = r_q;
    assign bus.g        = g_q;
    assign bus.b        = b_q;
    assign bus.valid    = valid_q;
    assign bus.overflow = overflow_q;
    assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_foreground_linebuf_m.sv
// tb_foreground_linebuf_m: directed table-driven bench for the line-buffer sprite engine
module tb_foreground_linebuf_m;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    foreground_linebuf_if #(.VRAM_ADDR_WIDTH(10)) bus ();
    foreground_linebuf_m dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [7:0] x;
        logic       vis;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [6:0] px(logic v, logic [1:0] r, logic [1:0] g, logic [1:0] b);
        return {v, r, g, b};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wr(int a, logic [7:0] d);
        @(negedge clk);
        bus.vram_we   = 1'b1;
        bus.vram_addr = 10'(a);
        bus.vram_data = d;
        @(negedge clk);
        bus.vram_we   = 1'b0;
    endtask

    task automatic obj(int k, logic [7:0] x, logic [7:0] y, logic [7:0] attr, logic [2:0] col);
        wr(512 + 4*k, x);
        wr(512 + 4*k + 1, y);
        wr(512 + 4*k + 2, attr);
        wr(512 + 4*k + 3, {5'b0, col});
    endtask

    task automatic row(int p, int r, logic [7:0] hi, logic [7:0] lo);
        wr(16*p + 2*r, hi);
        wr(16*p + 2*r + 1, lo);
    endtask

    task automatic park_all();
        for (int k = 0; k < 64; k++) wr(512 + 4*k + 1, 8'd200);
    endtask

    task automatic pulse(logic [7:0] y);
        @(negedge clk);
        bus.line_start = 1'b1;
        bus.line_y     = y;
        @(negedge clk);
        bus.line_start = 1'b0;
    endtask

    task automatic new_line(logic [7:0] y);
        pulse(y);
        repeat (150) @(negedge clk);
    endtask

    task automatic add(logic [7:0] x, logic vis, logic [6:0] e);
        vec_t v;
        v.x   = x;
        v.vis = vis;
        v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic apply(string nm);
        foreach (tbl[i]) begin
            @(negedge clk);
            bus.xp      = tbl[i].x;
            bus.visible = tbl[i].vis;
            @(negedge clk);
            chk($sformatf("%s x=%0d", nm, tbl[i].x), 32'({bus.valid, bus.r, bus.g, bus.b}), 32'(tbl[i].exp));
        end
        tbl.delete();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.xp = '0; bus.visible = 1'b0; bus.line_start = 1'b0; bus.line_y = '0;
        bus.vram_we = 1'b0; bus.vram_addr = '0; bus.vram_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_outputs", 32'({bus.valid, bus.r, bus.g, bus.b, bus.overflow, bus.overrun}), 32'(0));
        for (int a = 0; a < 512; a++) wr(a, 8'h00);
        park_all();
        for (int r = 0; r < 8; r++) row(0, r, 8'hFF, 8'hFF);
        row(1, 0, 8'h00, 8'h55);
        row(2, 1, 8'hFF, 8'hFF);
        row(2, 6, 8'hF0, 8'h1B);

        // single solid object, latency and edges
        obj(0, 8'd100, 8'd50, 8'h00, 3'b101);
        new_line(8'd52);
        new_line(8'd53);
        @(negedge clk);
        bus.xp = 8'd99; bus.visible = 1'b1;
        @(negedge clk);
        chk("lat_x99", 32'(bus.valid), 32'(0));
        bus.xp = 8'd100;
        #1;
        chk("lat_before_edge", 32'(bus.valid), 32'(0));
        @(posedge clk);
        #1;
        chk("lat_after_edge", 32'({bus.valid, bus.r, bus.g, bus.b}), 32'(px(1, 3, 0, 3)));
        for (int x = 100; x < 108; x++) add(8'(x), 1'b1, px(1, 3, 0, 3));
        add(8'd99, 1'b1, 7'd0);
        add(8'd108, 1'b1, 7'd0);
        add(8'd100, 1'b0, 7'd0);
        apply("solid");

        // reset in the middle of drawing clears both banks
        pulse(8'd54);
        repeat (70) @(negedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_flags", 32'({bus.overflow, bus.overrun}), 32'(0));
        for (int x = 0; x < 256; x++) add(8'(x), 1'b1, 7'd0);
        apply("rst_mid");

        // priority: obj3 transparent left half lets obj7 through
        wr(512 + 1, 8'd200);
        obj(3, 8'd10, 8'd60, 8'h01, 3'b010);
        obj(7, 8'd10, 8'd60, 8'h00, 3'b100);
        new_line(8'd60);
        new_line(8'd61);
        for (int x = 10; x < 14; x++) add(8'(x), 1'b1, px(1, 3, 0, 0));
        for (int x = 14; x < 18; x++) add(8'(x), 1'b1, px(1, 0, 1, 0));
        add(8'd9, 1'b1, 7'd0);
        add(8'd18, 1'b1, 7'd0);
        apply("priority");

        // ten objects on line 40, only the first eight survive
        wr(512 + 12 + 1, 8'd200);
        wr(512 + 28 + 1, 8'd200);
        for (int k = 0; k < 9; k++) obj(k, 8'(20*k), 8'd33, 8'h00, 3'b111);
        obj(9, 8'd180, 8'd40, 8'h00, 3'b111);
        new_line(8'd40);
        new_line(8'd41);
        chk("overflow_line40", 32'(bus.overflow), 32'(1));
        for (int k = 0; k < 8; k++) add(8'(20*k), 1'b1, px(1, 3, 3, 3));
        add(8'd160, 1'b1, 7'd0);
        add(8'd180, 1'b1, 7'd0);
        apply("overflow");
        new_line(8'd42);
        chk("overflow_line41", 32'(bus.overflow), 32'(0));
        add(8'd180, 1'b1, px(1, 3, 3, 3));
        add(8'd0, 1'b1, 7'd0);
        apply("one_obj");

        // mirrored object at the right edge, and an object on the last line
        park_all();
        obj(5, 8'd252, 8'd100, 8'h62, 3'b111);
        obj(1, 8'd30, 8'd255, 8'h00, 3'b001);
        new_line(8'd101);
        new_line(8'd254);
        add(8'd251, 1'b1, 7'd0);
        add(8'd252, 1'b1, px(1, 3, 3, 3));
        add(8'd253, 1'b1, px(1, 2, 2, 2));
        add(8'd254, 1'b1, px(1, 1, 1, 1));
        add(8'd255, 1'b1, 7'd0);
        add(8'd2, 1'b1, 7'd0);
        add(8'd3, 1'b1, 7'd0);
        apply("flip_clip");
        new_line(8'd255);
        add(8'd30, 1'b1, 7'd0);
        apply("line254");
        new_line(8'd0);
        add(8'd30, 1'b1, px(1, 0, 0, 3));
        apply("line255");
        new_line(8'd1);
        add(8'd30, 1'b1, 7'd0);
        apply("line0");

        // early line_start
        chk("overrun_before", 32'(bus.overrun), 32'(0));
        park_all();
        obj(2, 8'd50, 8'd70, 8'h00, 3'b010);
        new_line(8'd69);
        pulse(8'd70);
        repeat (20) @(negedge clk);
        pulse(8'd71);
        chk("overrun_set", 32'(bus.overrun), 32'(1));
        repeat (150) @(negedge clk);
        new_line(8'd72);
        chk("overrun_sticky", 32'(bus.overrun), 32'(1));
        add(8'd50, 1'b1, px(1, 0, 3, 0));
        add(8'd57, 1'b1, px(1, 0, 3, 0));
        add(8'd49, 1'b1, 7'd0);
        apply("after_overrun");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
